// File: rtl/cpu_pkg.sv
// cpu_pkg: opcodes, ALU modes, instruction fields and FSM/class types for the instruction sequencer
package cpu_pkg;
  localparam logic [3:0] OP_LD  = 4'h0;
  localparam logic [3:0] OP_ST  = 4'h1;
  localparam logic [3:0] OP_MI  = 4'h2;
  localparam logic [3:0] OP_MR  = 4'h3;
  localparam logic [3:0] OP_SUM = 4'h4;
  localparam logic [3:0] OP_SB  = 4'h5;
  localparam logic [3:0] OP_ANR = 4'h6;
  localparam logic [3:0] OP_CM  = 4'h7;
  localparam logic [3:0] OP_ORR = 4'h8;
  localparam logic [3:0] OP_XRR = 4'h9;
  localparam logic [3:0] OP_ORI = 4'hA;
  localparam logic [3:0] OP_XRI = 4'hB;
  localparam logic [3:0] OP_SMI = 4'hC;
  localparam logic [3:0] OP_SBI = 4'hD;
  localparam logic [3:0] OP_ANI = 4'hE;
  localparam logic [3:0] OP_CMI = 4'hF;

  localparam logic [2:0] MODE_ADD = 3'b000;
  localparam logic [2:0] MODE_SUB = 3'b001;
  localparam logic [2:0] MODE_AND = 3'b100;
  localparam logic [2:0] MODE_OR  = 3'b101;
  localparam logic [2:0] MODE_XOR = 3'b110;
  localparam logic [2:0] MODE_CMP = 3'b111;

  localparam int OP_MSB = 7;
  localparam int OP_LSB = 4;
  localparam int RD_MSB = 3;
  localparam int RD_LSB = 2;
  localparam int RS_MSB = 1;
  localparam int RS_LSB = 0;

  typedef enum logic [2:0] {S_IDLE, S_SRC_RD, S_DST_RD, S_WB, S_DONE} state_e;
  typedef enum logic [2:0] {CLS_RR, CLS_IMM, CLS_MR, CLS_MI, CLS_ILL} cls_e;

  function automatic cls_e cls_of(input logic [3:0] op);
    case (op)
      OP_LD, OP_ST: return CLS_ILL;
      OP_MI: return CLS_MI;
      OP_MR: return CLS_MR;
      OP_SUM, OP_SB, OP_ANR, OP_ORR, OP_XRR, OP_CM: return CLS_RR;
      default: return CLS_IMM;
    endcase
  endfunction

  function automatic logic [2:0] mode_of(input logic [3:0] op);
    case (op)
      OP_SB, OP_SBI: return MODE_SUB;
      OP_ANR, OP_ANI: return MODE_AND;
      OP_ORR, OP_ORI: return MODE_OR;
      OP_XRR, OP_XRI: return MODE_XOR;
      OP_CM, OP_CMI: return MODE_CMP;
      default: return MODE_ADD;
    endcase
  endfunction
endpackage

// File: rtl/instr_sequencer_if.sv
// instr_sequencer_if: instruction handshake plus register-file/ALU control and data bundle
interface instr_sequencer_if #(parameter int DATA_W = 8);
  logic              instr_valid;
  logic [7:0]        instruction;
  logic              instr_ready;
  logic [DATA_W-1:0] data_bus_out;
  logic [DATA_W-1:0] alu_sum;
  logic              alu_zero;
  logic              alu_carry;
  logic [1:0]        register_select;
  logic              mem_enable;
  logic              read_write;
  logic [DATA_W-1:0] data_bus_in;
  logic              alu_enable;
  logic [2:0]        mode;
  logic [DATA_W-1:0] immediate_input;
  logic              zero_flag;
  logic              carry_flag;
  logic              done;
  logic              illegal;
  modport slave (
    input  instr_valid, instruction, data_bus_out, alu_sum, alu_zero, alu_carry,
    output instr_ready, register_select, mem_enable, read_write, data_bus_in,
           alu_enable, mode, immediate_input, zero_flag, carry_flag, done, illegal
  );
  modport master (
    output instr_valid, instruction, data_bus_out, alu_sum, alu_zero, alu_carry,
    input  instr_ready, register_select, mem_enable, read_write, data_bus_in,
           alu_enable, mode, immediate_input, zero_flag, carry_flag, done, illegal
  );
endinterface

// File: rtl/instr_decode.sv
// instr_decode: splits a latched instruction into class, ALU mode, register fields and immediate
module instr_decode
  import cpu_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic [7:0]        instr,
  output cls_e              cls,
  output logic [2:0]        mode,
  output logic [1:0]        rd,
  output logic [1:0]        rs,
  output logic [DATA_W-1:0] imm,
  output logic              illegal
);
  assign cls     = cls_of(instr[OP_MSB:OP_LSB]);
  assign mode    = mode_of(instr[OP_MSB:OP_LSB]);
  assign rd      = instr[RD_MSB:RD_LSB];
  assign rs      = instr[RS_MSB:RS_LSB];
  assign imm     = {{(DATA_W-2){instr[RS_MSB]}}, instr[RS_MSB:RS_LSB]};
  assign illegal = cls == CLS_ILL;
endmodule

// File: rtl/instr_sequencer.sv
// instr_sequencer: multi-cycle FSM sequencing register-file reads, ALU execute and writeback
module instr_sequencer
  import cpu_pkg::*;
#(
  parameter int DATA_W  = 8,
  parameter int RF_LAT  = 1,
  parameter int ALU_LAT = 1
) (
  input logic              clk,
  input logic              reset,
  instr_sequencer_if.slave bus
);
  localparam int CNT_W = $clog2(RF_LAT + ALU_LAT + 2);
  localparam logic [CNT_W-1:0] SRC_LAST = CNT_W'(RF_LAT);
  localparam logic [CNT_W-1:0] DST_LAST = CNT_W'(RF_LAT + ALU_LAT);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [7:0]        instr_q, instr_d;
  logic [DATA_W-1:0] opnd_q, opnd_d, res_q, res_d;
  logic              zero_q, zero_d, carry_q, carry_d;

  cls_e              cls, new_cls;
  logic [2:0]        op_mode;
  logic [1:0]        rd, rs;
  logic [DATA_W-1:0] imm;
  logic              ill;

  logic              ready, mem_en, rw, alu_en, done, illegal;
  logic [1:0]        sel;
  logic [2:0]        mode;
  logic [DATA_W-1:0] dbi, imm_in;

  instr_decode #(.DATA_W(DATA_W)) u_dec (
    .instr(instr_q), .cls(cls), .mode(op_mode), .rd(rd), .rs(rs), .imm(imm), .illegal(ill)
  );

  assign new_cls = cls_of(bus.instruction[OP_MSB:OP_LSB]);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    instr_d = instr_q;
    opnd_d  = opnd_q;
    res_d   = res_q;
    zero_d  = zero_q;
    carry_d = carry_q;
    ready   = 1'b0;
    mem_en  = 1'b0;
    rw      = 1'b1;
    alu_en  = 1'b0;
    sel     = '0;
    dbi     = '0;
    mode    = '0;
    imm_in  = '0;
    done    = 1'b0;
    illegal = 1'b0;
    case (state_q)
      S_IDLE: begin
        ready = 1'b1;
        if (bus.instr_valid) begin
          instr_d = bus.instruction;
          cnt_d   = '0;
          state_d = (new_cls == CLS_RR || new_cls == CLS_MR) ? S_SRC_RD :
                    new_cls == CLS_IMM ? S_DST_RD : new_cls == CLS_MI ? S_WB : S_DONE;
        end
      end
      S_SRC_RD: begin
        mem_en = 1'b1;
        sel    = rs;
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == SRC_LAST) begin
          opnd_d  = bus.data_bus_out;
          cnt_d   = '0;
          state_d = cls == CLS_MR ? S_WB : S_DST_RD;
        end
      end
      // rd is read RF_LAT cycles, then the ALU needs ALU_LAT more before its result is valid
      S_DST_RD: begin
        mem_en = 1'b1;
        sel    = rd;
        alu_en = 1'b1;
        mode   = op_mode;
        imm_in = cls == CLS_RR ? opnd_q : imm;
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == DST_LAST) begin
          res_d   = bus.alu_sum;
          zero_d  = bus.alu_zero;
          carry_d = bus.alu_carry;
          cnt_d   = '0;
          state_d = op_mode == MODE_CMP ? S_DONE : S_WB;
        end
      end
      S_WB: begin
        mem_en  = 1'b1;
        rw      = 1'b0;
        sel     = rd;
        dbi     = cls == CLS_MR ? opnd_q : cls == CLS_MI ? imm : res_q;
        state_d = S_DONE;
      end
      S_DONE: begin
        done    = 1'b1;
        illegal = ill;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      instr_q <= '0;
      opnd_q  <= '0;
      res_q   <= '0;
      zero_q  <= 1'b0;
      carry_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      instr_q <= instr_d;
      opnd_q  <= opnd_d;
      res_q   <= res_d;
      zero_q  <= zero_d;
      carry_q <= carry_d;
    end
  end

  assign bus.instr_ready     = ready;
  assign bus.mem_enable      = mem_en;
  assign bus.read_write      = rw;
  assign bus.register_select = sel;
  assign bus.data_bus_in     = dbi;
  assign bus.alu_enable      = alu_en;
  assign bus.mode            = mode;
  assign bus.immediate_input = imm_in;
  assign bus.zero_flag       = zero_q;
  assign bus.carry_flag      = carry_q;
  assign bus.done            = done;
  assign bus.illegal         = illegal;
endmodule
